// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial RAM/IO controller serving the instruction fetcher and the load/store buffer.
// Optional MC_IO_STALL_EN: hold IO-space store bytes while io_buffer_full is high.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clr_in,
  input  logic              if_to_mc_ready,
  input  logic [ADDR_W-1:0] if_to_mc_PC,
  output logic              mc_to_if_ready,
  output logic [31:0]       mc_to_if_inst,
  input  logic              lsb_to_mc_ready,
  input  logic              lsb_to_mc_wr,
  input  logic [1:0]        lsb_to_mc_len,
  input  logic [ADDR_W-1:0] lsb_to_mc_addr,
  input  logic [31:0]       lsb_to_mc_data,
  output logic              mc_to_lsb_ready,
  output logic [31:0]       mc_to_lsb_data,
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr,
  input  logic              io_buffer_full
);
  typedef enum logic [1:0] {S_IDLE, S_IF_READ, S_LS_READ, S_LS_WRITE} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [2:0]        r_n;
  logic [2:0]        r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_res;
  logic              r_wr;
  logic              w_idle;
  logic              w_stall;
  logic [2:0]        w_lsb_n;
  logic [ADDR_W-1:0] w_wa;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_res;

  assign w_idle  = r_state == S_IDLE;
  assign w_lsb_n = lsb_to_mc_len == 2'b00 ? 3'd1 : lsb_to_mc_len == 2'b01 ? 3'd2 : 3'd4;
  // In IDLE the first store byte comes straight from the request so it hits the bus at acceptance
  assign w_wa    = w_idle ? lsb_to_mc_addr : r_addr + ADDR_W'(r_idx);
  assign w_wbyte = w_idle ? lsb_to_mc_data[7:0] : r_wdata[{r_idx[1:0], 3'b000} +: 8];
  // r_idx counts cycles since acceptance; the byte arriving now belongs to index r_idx-2
  assign w_res   = r_res | ({24'b0, mem_din} << {r_idx - 3'd2, 3'b000});
  assign mem_wr  = r_wr & rdy_in;
`ifdef MC_IO_STALL_EN
  assign w_stall = w_wa[17:16] == 2'b11 && io_buffer_full;
`else
  logic w_unused_io;
  assign w_unused_io = io_buffer_full;
  assign w_stall     = 1'b0;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state         <= S_IDLE;
      r_addr          <= '0;
      r_n             <= '0;
      r_idx           <= '0;
      r_wdata         <= '0;
      r_res           <= '0;
      r_wr            <= 1'b0;
      mem_a           <= '0;
      mem_dout        <= '0;
      mc_to_if_ready  <= 1'b0;
      mc_to_if_inst   <= '0;
      mc_to_lsb_ready <= 1'b0;
      mc_to_lsb_data  <= '0;
    end else if (rdy_in) begin
      mc_to_if_ready  <= 1'b0;
      mc_to_lsb_ready <= 1'b0;
      case (r_state)
        S_IDLE: if (!mc_to_if_ready && !mc_to_lsb_ready) begin
          if (lsb_to_mc_ready) begin
            r_addr  <= lsb_to_mc_addr;
            r_n     <= w_lsb_n;
            r_wdata <= lsb_to_mc_data;
            r_res   <= '0;
            if (lsb_to_mc_wr) begin
              r_state  <= S_LS_WRITE;
              r_idx    <= w_stall ? 3'd0 : 3'd1;
              mem_a    <= w_stall ? '0 : lsb_to_mc_addr;
              mem_dout <= w_wbyte;
              r_wr     <= ~w_stall;
            end else begin
              r_state <= S_LS_READ;
              r_idx   <= 3'd1;
              mem_a   <= lsb_to_mc_addr;
            end
          end else if (if_to_mc_ready && !clr_in) begin
            r_state <= S_IF_READ;
            r_addr  <= if_to_mc_PC;
            r_n     <= 3'd4;
            r_idx   <= 3'd1;
            r_res   <= '0;
            mem_a   <= if_to_mc_PC;
          end
        end
        S_LS_WRITE: if (r_idx == r_n) begin
          r_state         <= S_IDLE;
          r_wr            <= 1'b0;
          mem_a           <= '0;
          mc_to_lsb_ready <= 1'b1;
        end else begin
          mem_a    <= w_stall ? '0 : w_wa;
          mem_dout <= w_wbyte;
          r_wr     <= ~w_stall;
          r_idx    <= r_idx + {2'b00, ~w_stall};
        end
        default: if (clr_in) begin
          r_state <= S_IDLE;
          mem_a   <= '0;
        end else begin
          mem_a <= r_idx < r_n ? r_addr + ADDR_W'(r_idx) : '0;
          r_idx <= r_idx + 3'd1;
          if (r_idx >= 3'd2) r_res <= w_res;
          if (r_idx == r_n + 3'd1) begin
            r_state <= S_IDLE;
            if (r_state == S_IF_READ) begin
              mc_to_if_ready <= 1'b1;
              mc_to_if_inst  <= w_res;
            end else begin
              mc_to_lsb_ready <= 1'b1;
              mc_to_lsb_data  <= w_res;
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed self-checking bench for mem_ctrl with a registered-read byte RAM model.
module tb_mem_ctrl;
  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, clr_in;
  logic        if_to_mc_ready;
  logic [31:0] if_to_mc_PC;
  logic        mc_to_if_ready;
  logic [31:0] mc_to_if_inst;
  logic        lsb_to_mc_ready, lsb_to_mc_wr;
  logic [1:0]  lsb_to_mc_len;
  logic [31:0] lsb_to_mc_addr, lsb_to_mc_data;
  logic        mc_to_lsb_ready;
  logic [31:0] mc_to_lsb_data;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full;
  logic [7:0]  ram [0:262143];
  logic        pre_we;
  logic [17:0] pre_a;
  logic [7:0]  pre_d;
  int          checks = 0;
  int          errors = 0;

  always #5 clk_in = ~clk_in;

  mem_ctrl dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .if_to_mc_ready(if_to_mc_ready), .if_to_mc_PC(if_to_mc_PC),
    .mc_to_if_ready(mc_to_if_ready), .mc_to_if_inst(mc_to_if_inst),
    .lsb_to_mc_ready(lsb_to_mc_ready), .lsb_to_mc_wr(lsb_to_mc_wr),
    .lsb_to_mc_len(lsb_to_mc_len), .lsb_to_mc_addr(lsb_to_mc_addr),
    .lsb_to_mc_data(lsb_to_mc_data), .mc_to_lsb_ready(mc_to_lsb_ready),
    .mc_to_lsb_data(mc_to_lsb_data), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_a(mem_a), .mem_wr(mem_wr), .io_buffer_full(io_buffer_full)
  );

  always @(posedge clk_in) begin
    if (pre_we) ram[pre_a] <= pre_d;
    else if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  task automatic poke(input logic [17:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_a = a; pre_d = d;
    @(negedge clk_in);
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    rst_in = 1'b1; rdy_in = 1'b1; clr_in = 1'b0; pre_we = 1'b0; pre_a = '0; pre_d = '0;
    if_to_mc_ready = 1'b0; if_to_mc_PC = '0; lsb_to_mc_ready = 1'b0; lsb_to_mc_wr = 1'b0;
    lsb_to_mc_len = '0; lsb_to_mc_addr = '0; lsb_to_mc_data = '0; io_buffer_full = 1'b0;
    repeat (2) @(negedge clk_in);
    checks++;
    if ({mc_to_if_ready, mc_to_lsb_ready, mem_wr, mem_dout, mem_a, mc_to_if_inst, mc_to_lsb_data} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got a=%h dout=%h wr=%b ifr=%b lsbr=%b inst=%h data=%h exp all 0",
               mem_a, mem_dout, mem_wr, mc_to_if_ready, mc_to_lsb_ready, mc_to_if_inst, mc_to_lsb_data);
    end
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_in);
      checks++;
      if ({mc_to_if_ready, mc_to_lsb_ready, mem_wr} !== 3'b000 || mem_a !== 32'h0) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got ifr=%b lsbr=%b wr=%b a=%h exp 0", i, mc_to_if_ready, mc_to_lsb_ready, mem_wr, mem_a);
      end
    end
  endtask

  task automatic test_fetch();
    logic [31:0] ea;
    poke(18'h1000, 8'h13); poke(18'h1001, 8'h05); poke(18'h1002, 8'h00); poke(18'h1003, 8'h00);
    if_to_mc_PC = 32'h1000; if_to_mc_ready = 1'b1;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk_in);
      ea = i < 4 ? 32'h1000 + 32'(i) : 32'h0;
      checks++;
      if (mem_a !== ea) begin errors++; $display("FAIL fetch_addr cyc %0d got %h exp %h", i, mem_a, ea); end
      checks++;
      if (mc_to_if_ready !== (i == 5)) begin errors++; $display("FAIL fetch_pulse cyc %0d got %b exp %b", i, mc_to_if_ready, i == 5); end
      if (i >= 5) begin
        checks++;
        if (mc_to_if_inst !== 32'h00000513) begin errors++; $display("FAIL fetch_inst cyc %0d got %h exp 00000513", i, mc_to_if_inst); end
        if_to_mc_ready = 1'b0;
      end
    end
  endtask

  task automatic test_arb_store();
    logic [31:0] wd;
    wd = 32'hDEADBEEF;
    if_to_mc_PC = 32'h1000; if_to_mc_ready = 1'b1;
    lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_len = 2'b10;
    lsb_to_mc_addr = 32'h2000; lsb_to_mc_data = wd;
    for (int i = 0; i <= 11; i++) begin
      @(negedge clk_in);
      if (i < 4) begin
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h2000 + 32'(i) || mem_dout !== wd[8*i +: 8]) begin
          errors++;
          $display("FAIL store_byte cyc %0d got wr=%b a=%h d=%h exp wr=1 a=%h d=%h", i, mem_wr, mem_a, mem_dout, 32'h2000 + 32'(i), wd[8*i +: 8]);
        end
      end
      checks++;
      if (mc_to_lsb_ready !== (i == 4)) begin errors++; $display("FAIL store_pulse cyc %0d got %b exp %b", i, mc_to_lsb_ready, i == 4); end
      if (i == 4) begin
        lsb_to_mc_ready = 1'b0;
        checks++;
        if (mem_wr !== 1'b0) begin errors++; $display("FAIL store_wr_end got %b exp 0", mem_wr); end
      end
      if (i == 5 || i == 6) begin
        checks++;
        if (mem_a !== (i == 5 ? 32'h0 : 32'h1000)) begin errors++; $display("FAIL arb_gap cyc %0d got a=%h", i, mem_a); end
      end
      checks++;
      if (mc_to_if_ready !== (i == 11)) begin errors++; $display("FAIL arb_fetch_pulse cyc %0d got %b exp %b", i, mc_to_if_ready, i == 11); end
      if (i == 11) begin
        if_to_mc_ready = 1'b0;
        checks++;
        if (mc_to_if_inst !== 32'h00000513) begin errors++; $display("FAIL arb_fetch_inst got %h exp 00000513", mc_to_if_inst); end
      end
    end
    @(negedge clk_in);
  endtask

  task automatic test_loads();
    logic [31:0] la [4];
    logic [1:0]  ll [4];
    int          ln [4];
    logic [31:0] le [4];
    logic [31:0] ea;
    la = '{32'h2002, 32'h2000, 32'h2000, 32'h2001};
    ll = '{2'b01, 2'b00, 2'b10, 2'b11};
    ln = '{2, 1, 4, 4};
    le = '{32'h00008234, 32'h000000EF, 32'h8234BEEF, 32'h778234BE};
    poke(18'h2002, 8'h34); poke(18'h2003, 8'h82); poke(18'h2004, 8'h77);
    for (int t = 0; t < 4; t++) begin
      lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_len = ll[t]; lsb_to_mc_addr = la[t];
      for (int i = 0; i <= ln[t] + 1; i++) begin
        @(negedge clk_in);
        ea = i < ln[t] ? la[t] + 32'(i) : 32'h0;
        checks++;
        if (mem_a !== ea) begin errors++; $display("FAIL load%0d_addr cyc %0d got %h exp %h", t, i, mem_a, ea); end
        checks++;
        if (mc_to_lsb_ready !== (i == ln[t] + 1)) begin errors++; $display("FAIL load%0d_pulse cyc %0d got %b", t, i, mc_to_lsb_ready); end
      end
      lsb_to_mc_ready = 1'b0;
      checks++;
      if (mc_to_lsb_data !== le[t]) begin errors++; $display("FAIL load%0d_data got %h exp %h", t, mc_to_lsb_data, le[t]); end
      @(negedge clk_in);
    end
  endtask

  task automatic test_clear();
    poke(18'h0, 8'h93); poke(18'h1, 8'h00); poke(18'h2, 8'h10); poke(18'h3, 8'h00);
    if_to_mc_PC = 32'h1000; if_to_mc_ready = 1'b1;
    for (int i = 0; i <= 7; i++) begin
      @(negedge clk_in);
      if (i == 2) begin clr_in = 1'b1; if_to_mc_ready = 1'b0; end
      if (i == 3) begin
        clr_in = 1'b0;
        checks++;
        if (mem_a !== 32'h0 || mc_to_if_inst !== 32'h00000513) begin
          errors++; $display("FAIL clr_fetch_abort got a=%h inst=%h exp a=0 inst=00000513", mem_a, mc_to_if_inst);
        end
      end
      if (i >= 3) begin
        checks++;
        if (mc_to_if_ready !== 1'b0) begin errors++; $display("FAIL clr_fetch_pulse cyc %0d got 1 exp 0", i); end
      end
    end
    if_to_mc_PC = 32'h0; if_to_mc_ready = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk_in);
      checks++;
      if (mc_to_if_ready !== (i == 5)) begin errors++; $display("FAIL refetch_pulse cyc %0d got %b exp %b", i, mc_to_if_ready, i == 5); end
    end
    if_to_mc_ready = 1'b0;
    checks++;
    if (mc_to_if_inst !== 32'h00100093) begin errors++; $display("FAIL refetch_inst got %h exp 00100093", mc_to_if_inst); end
    @(negedge clk_in);
    lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b0; lsb_to_mc_len = 2'b10; lsb_to_mc_addr = 32'h2000;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk_in);
      if (i == 1) begin clr_in = 1'b1; lsb_to_mc_ready = 1'b0; end
      if (i == 2) clr_in = 1'b0;
      checks++;
      if (mc_to_lsb_ready !== 1'b0) begin errors++; $display("FAIL clr_load_pulse cyc %0d got 1 exp 0", i); end
    end
    lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_len = 2'b10;
    lsb_to_mc_addr = 32'h2010; lsb_to_mc_data = 32'h11223344;
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_in);
      if (i == 1) clr_in = 1'b1;
      if (i == 2) begin
        clr_in = 1'b0;
        checks++;
        if (mem_wr !== 1'b1 || mem_a !== 32'h2012 || mem_dout !== 8'h22) begin
          errors++; $display("FAIL clr_store_byte got wr=%b a=%h d=%h exp 1 2012 22", mem_wr, mem_a, mem_dout);
        end
      end
      if (i == 4) lsb_to_mc_ready = 1'b0;
      checks++;
      if (mc_to_lsb_ready !== (i == 4)) begin errors++; $display("FAIL clr_store_pulse cyc %0d got %b exp %b", i, mc_to_lsb_ready, i == 4); end
    end
    @(negedge clk_in);
  endtask

  task automatic test_freeze();
    lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_len = 2'b00;
    lsb_to_mc_addr = 32'h2020; lsb_to_mc_data = 32'h000000A5;
    @(negedge clk_in);
    lsb_to_mc_ready = 1'b0; rdy_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (mem_wr !== 1'b0 || mem_a !== 32'h2020 || mc_to_lsb_ready !== 1'b0) begin
        errors++; $display("FAIL freeze_hold cyc %0d got wr=%b a=%h lsbr=%b exp 0 2020 0", i, mem_wr, mem_a, mc_to_lsb_ready);
      end
      @(negedge clk_in);
    end
    rdy_in = 1'b1;
    #1;
    checks++;
    if (mem_wr !== 1'b1 || mem_dout !== 8'hA5) begin errors++; $display("FAIL freeze_resume got wr=%b d=%h exp 1 a5", mem_wr, mem_dout); end
    @(negedge clk_in);
    checks++;
    if (mc_to_lsb_ready !== 1'b1) begin errors++; $display("FAIL freeze_pulse got %b exp 1", mc_to_lsb_ready); end
    @(negedge clk_in);
  endtask

  task automatic test_io_stall();
    int p;
`ifdef MC_IO_STALL_EN
    p = 4;
`else
    p = 1;
`endif
    io_buffer_full = 1'b1;
    lsb_to_mc_ready = 1'b1; lsb_to_mc_wr = 1'b1; lsb_to_mc_len = 2'b00;
    lsb_to_mc_addr = 32'h30000; lsb_to_mc_data = 32'h0000005A;
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk_in);
      if (i == 2) io_buffer_full = 1'b0;
      checks++;
      if (mem_wr !== (i == p - 1) || mem_a !== (i == p - 1 ? 32'h30000 : 32'h0)) begin
        errors++; $display("FAIL io_bus cyc %0d got wr=%b a=%h exp wr=%b", i, mem_wr, mem_a, i == p - 1);
      end
      if (i == p) lsb_to_mc_ready = 1'b0;
      checks++;
      if (mc_to_lsb_ready !== (i == p)) begin errors++; $display("FAIL io_pulse cyc %0d got %b exp %b", i, mc_to_lsb_ready, i == p); end
    end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_arb_store();
    test_loads();
    test_clear();
    test_freeze();
    test_io_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
